// File: rtl/colour_fader.sv
// colour_fader
// Turns the 3-bit colour code from the LED sequencer into a smooth fade on a
// tri-colour LED. Each channel keeps a brightness level that steps by one
// toward its target (0 or MAX) once per fade interval. A free-running PWM
// counter is compared against the levels to give the registered LED outputs.
//
// Parameters:
//   PWM_BITS  width of the PWM counter and of each level (MAX = 2^PWM_BITS-1)
//   FADE_DIV  number of complete PWM periods per level step (>= 1)
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   enable    1 = run, 0 = freeze the fade and blank the outputs
//   colour    {red, green, blue} target code, sampled every cycle
//   led_r/g/b registered PWM outputs
//   busy      high while any level differs from its target
module colour_fader #(
  parameter int PWM_BITS = 4,
  parameter int FADE_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] colour,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy
);

  localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_LVL   = '1;
  localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_DIV - 1);

  // Channel index 0 = red, 1 = green, 2 = blue; colour bit (2 - ch).
  logic [2:0]          colour_q, colour_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [FADE_W-1:0]   fade_q, fade_d;
  logic [PWM_BITS-1:0] level_q [3];
  logic [PWM_BITS-1:0] level_d [3];
  logic [PWM_BITS-1:0] target  [3];
  logic [2:0]          led_q, led_d;
  logic [2:0]          differs;
  logic                period_end;
  logic                step;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    colour_d   = colour;
    pwm_d      = '0;
    fade_d     = fade_q;
    step       = 1'b0;
    period_end = enable && (pwm_q == MAX_LVL);
    led_d      = '0;
    differs    = '0;

    if (enable) begin
      pwm_d = (pwm_q == MAX_LVL) ? '0 : pwm_q + 1'b1;
    end

    if (period_end) begin
      if (fade_q == FADE_LAST) begin
        fade_d = '0;
        step   = 1'b1;
      end else begin
        fade_d = fade_q + 1'b1;
      end
    end

    for (int ch = 0; ch < 3; ch++) begin
      // Targets come from the registered code, so a colour change arriving
      // on a step edge only affects the following step.
      target[ch]  = colour_q[2-ch] ? MAX_LVL : '0;
      level_d[ch] = level_q[ch];
      if (step) begin
        if (level_q[ch] < target[ch]) begin
          level_d[ch] = level_q[ch] + 1'b1;
        end else if (level_q[ch] > target[ch]) begin
          level_d[ch] = level_q[ch] - 1'b1;
        end
      end
      led_d[ch]   = enable && (level_q[ch] > pwm_q);
      differs[ch] = (level_q[ch] != target[ch]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colour_q <= '0;
      pwm_q    <= '0;
      fade_q   <= '0;
      led_q    <= '0;
      // NOTE: the level array is three small flops, not a RAM, and it must
      // come out of reset at 0, so it is reset like any other register.
      for (int ch = 0; ch < 3; ch++) begin
        level_q[ch] <= '0;
      end
    end else begin
      colour_q <= colour_d;
      pwm_q    <= pwm_d;
      fade_q   <= fade_d;
      led_q    <= led_d;
      for (int ch = 0; ch < 3; ch++) begin
        level_q[ch] <= level_d[ch];
      end
    end
  end

  assign led_r = led_q[0];
  assign led_g = led_q[1];
  assign led_b = led_q[2];
  // Decoded from level and colour registers only.
  assign busy  = |differs;

endmodule
